// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction prefetch queue.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN  = 32;
   localparam int unsigned FETCH_DEPTH = 4;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] inst;
      logic [FETCH_XLEN-1:0] pc;
   } fetch_entry_t;

   // Width of a counter able to hold 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; power-of-two depth so pointers wrap naturally.
// Callers guard push against full and pop against empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type         T     = fetch_entry_t,
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic                       push,
   input  T                           wdata,
   input  logic                       pop,
   input  logic                       clear,
   output T                           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[PW'(i)] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// IF-stage prefetch front end: credit-limited AXI reads, PC tagging, and
// redirect handling that drops stale in-flight responses by count.
module inst_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = FETCH_XLEN,
   parameter int unsigned     DEPTH    = FETCH_DEPTH,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic                       redirect_en_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic [XLEN-1:0]            imem_araddr_o,
   output logic                       imem_arvalid_o,
   input  logic                       imem_arready_i,
   input  logic [XLEN-1:0]            imem_rdata_i,
   input  logic                       imem_rvalid_i,
   output logic                       imem_rready_o,
   output logic [XLEN-1:0]            inst_o,
   output logic [XLEN-1:0]            pc_o,
   output logic [XLEN-1:0]            pc_next_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

   localparam int unsigned     CW      = cnt_w(DEPTH);
   localparam int unsigned     SW      = CW + 1;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] ar_addr;
   logic            ar_valid;
   logic            ar_stale;
   logic [CW-1:0]   drop_cnt;

   fetch_entry_t    q_head;
   fetch_entry_t    q_wdata;
   logic [CW-1:0]   q_count;
   logic            q_full;
   logic            q_empty;
   logic [XLEN-1:0] pcq_head;
   logic [CW-1:0]   out_count;
   logic            pcq_full;
   logic            pcq_empty;

   logic            ar_fire;
   logic            r_fire;
   logic            r_drop;
   logic            q_push;
   logic            q_pop;
   logic            ar_free;
   logic [XLEN-1:0] pc_base;
   logic [SW-1:0]   occ_next;
   logic [SW-1:0]   out_next;
   logic            credit_next;

   // Handshake decode and next-cycle credit.
   always_comb begin
      ar_fire     = ar_valid & imem_arready_i;
      r_fire      = imem_rvalid_i;
      r_drop      = r_fire & (redirect_en_i | (drop_cnt != '0));
      q_push      = r_fire & ~r_drop & ~q_full;
      q_pop       = ~q_empty & ready_i & ~redirect_en_i;
      ar_free     = ~ar_valid | ar_fire;
      pc_base     = redirect_en_i ? redirect_pc_i : fetch_pc;
      occ_next    = redirect_en_i ? '0
                                  : SW'(q_count) + SW'(q_push) - SW'(q_pop);
      out_next    = SW'(out_count) + SW'(ar_fire) - SW'(r_fire);
      credit_next = (occ_next + out_next) < SW'(DEPTH);
   end

   // AR request register: a pending request holds its address even across a redirect.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         fetch_pc <= RESET_PC;
         ar_addr  <= RESET_PC;
         ar_valid <= 1'b0;
      end else if (ar_free) begin
         ar_valid <= credit_next;
         ar_addr  <= pc_base;
         fetch_pc <= credit_next ? pc_base + PC_STEP : pc_base;
      end else begin
         fetch_pc <= pc_base;
      end
   end

   // A request stranded by a redirect joins the drop count once it is accepted.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         drop_cnt <= '0;
         ar_stale <= 1'b0;
      end else if (redirect_en_i) begin
         drop_cnt <= CW'(out_next);
         ar_stale <= ar_valid & ~ar_fire;
      end else begin
         drop_cnt <= drop_cnt - CW'(r_drop) + CW'(ar_fire & ar_stale);
         if (ar_fire) begin
            ar_stale <= 1'b0;
         end
      end
   end

   assign q_wdata = '{inst: imem_rdata_i, pc: pcq_head};

   fetch_fifo #(
      .T     (fetch_entry_t),
      .DEPTH (DEPTH)
   ) u_inst_q (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .push    (q_push),
      .wdata   (q_wdata),
      .pop     (q_pop),
      .clear   (redirect_en_i),
      .rdata   (q_head),
      .count   (q_count),
      .full    (q_full),
      .empty   (q_empty)
   );

   // Issued-address tracker; its fill level is the outstanding read count.
   fetch_fifo #(
      .T     (logic [XLEN-1:0]),
      .DEPTH (DEPTH)
   ) u_pc_q (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .push    (ar_fire & ~pcq_full),
      .wdata   (ar_addr),
      .pop     (r_fire & ~pcq_empty),
      .clear   (1'b0),
      .rdata   (pcq_head),
      .count   (out_count),
      .full    (pcq_full),
      .empty   (pcq_empty)
   );

   assign imem_araddr_o  = ar_addr;
   assign imem_arvalid_o = ar_valid;
   assign imem_rready_o  = 1'b1;
   assign inst_o         = q_head.inst;
   assign pc_o           = q_head.pc;
   assign pc_next_o      = q_head.pc + PC_STEP;
   assign valid_o        = ~q_empty;
   assign occupancy_o    = q_count;

endmodule
